// File: rtl/wrap_mon_pkg.sv
// Shared types and default widths for the wrap event monitor.
// Optional feature macro: WRAP_MON_TIMESTAMP_EN adds a cycle timestamp to
// every queued wrap entry.
package wrap_mon_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TS_W  = 16;

  // Sequence tracker: SYNC waits for a zero sample, TRACK checks +1 steps.
  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_e;

  // Default-width queue entry; the top re-declares the same shape with its
  // own parameter values and hands it to the FIFO as a type parameter.
  typedef struct packed {
`ifdef WRAP_MON_TIMESTAMP_EN
    logic [DEF_TS_W-1:0]  ts;
`endif
    logic [DEF_CNT_W-1:0] idx;
  } wrap_entry_t;

  // Expected successor of a 2-bit counter value (3 wraps to 0).
  function automatic logic [1:0] seq_next(input logic [1:0] q);
    return q + 2'd1;
  endfunction

endpackage

// File: rtl/wrap_mon_fifo.sv
// Synchronous FIFO for wrap entries, parameterised on depth and entry type.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
// Optional feature macro (via the entry type): WRAP_MON_TIMESTAMP_EN.
module wrap_mon_fifo
  import wrap_mon_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  parameter type T     = wrap_entry_t
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  T                        i_data,
  output T                        o_head,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  T                 r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == FULL_LVL);
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && (r_level != '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage write; a full-with-pop push lands in the slot being vacated.
  // NOTE: the data array is deliberately not reset -- occupancy comes only from
  // the pointers and level, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  // NOTE: non-blocking assignments keep every register reading pre-edge values,
  // so the update order inside this block does not matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/wrap_event_monitor.sv
// Wrap event monitor: checks that an upstream 2-bit counter advances by one
// each cycle, numbers each valid wrap (done with value 3), queues it and
// hands it downstream over valid/ready. Sticky flags report sequence breaks,
// done inconsistencies and dropped pushes.
// Optional feature macro: WRAP_MON_TIMESTAMP_EN (cycle timestamp per entry,
// adds the out_ts port).
module wrap_event_monitor
  import wrap_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TS_W  = DEF_TS_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              q_in,
  input  logic                    done_in,
  input  logic                    err_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        out_data,
`ifdef WRAP_MON_TIMESTAMP_EN
  output logic [TS_W-1:0]         out_ts,
`endif
  output logic [$clog2(DEPTH):0]  level,
  output logic                    err_seq,
  output logic                    err_done,
  output logic                    overflow
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
`ifdef WRAP_MON_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
    logic [CNT_W-1:0] idx;
  } entry_t;

  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic [1:0]       r_q_prev;
  logic [CNT_W-1:0] r_wrap_cnt;
  logic             r_err_seq;
  logic             r_err_done;
  logic             r_overflow;

  logic             w_done_bad;
  logic             w_seq_ok;
  logic             w_seq_bad;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_drop;
  logic [LVL_W-1:0] w_level;
  entry_t           w_push_entry;
  entry_t           w_head;

  assign w_done_bad = (done_in != (q_in == 2'd3));
  assign w_seq_ok   = (q_in == seq_next(r_q_prev));

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SYNC;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: lock on a zero sample, drop back on any broken step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SYNC:    if (q_in == 2'd0) w_state_nxt = TRACK;
      TRACK:   if (!w_seq_ok)    w_state_nxt = SYNC;
      default: w_state_nxt = SYNC;
    endcase
  end

  // FSM outputs: sequence error and push request, both only while tracking.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_seq_bad = 1'b0;
    w_push    = 1'b0;
    case (r_state)
      TRACK: begin
        w_seq_bad = !w_seq_ok;
        w_push    = w_seq_ok && !w_done_bad && done_in && (q_in == 2'd3);
      end
      default: ;
    endcase
  end

  // Previous sample; only meaningful while tracking (loads 0 when locking).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_q_prev <= 2'd0;
    else if (w_state_nxt == TRACK) r_q_prev <= q_in;
  end

  // Wrap index; advances on every push request, dropped or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_wrap_cnt <= '0;
    else if (w_push) r_wrap_cnt <= r_wrap_cnt + 1'b1;
  end

`ifdef WRAP_MON_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  // Free-running cycle counter stamped into each entry at push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end
`endif

  // Assemble the entry pushed this cycle (index already incremented).
  always_comb begin
    w_push_entry     = '0;
    w_push_entry.idx = r_wrap_cnt + 1'b1;
`ifdef WRAP_MON_TIMESTAMP_EN
    w_push_entry.ts  = r_ts;
`endif
  end

  wrap_mon_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full)
  );

  assign out_valid = (w_level != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_drop    = w_push && w_full && !w_pop;
  assign level     = w_level;
  assign out_data  = out_valid ? w_head.idx : '0;
`ifdef WRAP_MON_TIMESTAMP_EN
  assign out_ts    = out_valid ? w_head.ts : '0;
`endif

  // Sticky flags: a set in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_seq  <= 1'b0;
      r_err_done <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_err_seq  <= w_seq_bad  || (r_err_seq  && !err_clr);
      r_err_done <= w_done_bad || (r_err_done && !err_clr);
      r_overflow <= w_drop     || (r_overflow && !err_clr);
    end
  end

  assign err_seq  = r_err_seq;
  assign err_done = r_err_done;
  assign overflow = r_overflow;

endmodule
